// File: rtl/ava_dma.sv
// ava_dma: Wishbone pipelined master that copies 32-bit words from system
// memory into VRAM (or pattern-fills VRAM) on behalf of the CPU.
// One request outstanding at a time; the bus is released for one cycle
// between words so the interconnect can rearbitrate.
// Optional feature macro: AVA_DMA_FILL_EN enables the pattern-fill mode.
module ava_dma #(
  parameter int LEN_WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic                 fill_en,
  input  logic [31:0]          fill_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_stall_i,
  input  logic                 wb_err_i
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, GAP, FIN} state_t;

  state_t               state;
  logic [29:0]          src_w;      // word addresses; byte offset is always 0
  logic [29:0]          dst_w;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 bus_state;
  logic                 unused_in;

  assign bus_state = (state == RD_REQ) || (state == RD_WAIT) ||
                     (state == WR_REQ) || (state == WR_WAIT);

`ifdef AVA_DMA_FILL_EN
  logic        fill_mode;
  logic [31:0] fill_word;
  assign unused_in = ^{src_addr[1:0], dst_addr[1:0]};
`else
  assign unused_in = ^{fill_en, fill_data, src_addr[1:0], dst_addr[1:0]};
`endif

  // Transfer FSM; every bus output and status flag is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src_w     <= '0;
      dst_w     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
`ifdef AVA_DMA_FILL_EN
      fill_mode <= 1'b0;
      fill_word <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (bus_state && wb_err_i) begin
        // Error wins over ack: abandon the word and release the bus.
        err      <= 1'b1;
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_sel_o <= 4'h0;
        done     <= 1'b1;
        state    <= FIN;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              src_w     <= src_addr[31:2];
              dst_w     <= dst_addr[31:2];
              remaining <= length;
              err       <= 1'b0;
              busy      <= 1'b1;
`ifdef AVA_DMA_FILL_EN
              fill_mode <= fill_en;
              fill_word <= fill_data;
`endif
              if (length == '0) begin
                done  <= 1'b1;
                state <= FIN;
              end else begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= 4'hF;
`ifdef AVA_DMA_FILL_EN
                if (fill_en) begin
                  wb_we_o  <= 1'b1;
                  wb_adr_o <= {dst_addr[31:2], 2'b00};
                  wb_dat_o <= fill_data;
                  state    <= WR_REQ;
                end else
`endif
                begin
                  wb_we_o  <= 1'b0;
                  wb_adr_o <= {src_addr[31:2], 2'b00};
                  state    <= RD_REQ;
                end
              end
            end
          end
          RD_REQ: begin
            if (!wb_stall_i) begin
              wb_stb_o <= 1'b0;
              wb_sel_o <= 4'h0;
              state    <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            // wb_dat_o doubles as the data register between read and write.
            if (wb_ack_i) begin
              wb_dat_o <= wb_dat_i;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_sel_o <= 4'hF;
              wb_adr_o <= {dst_w, 2'b00};
              state    <= WR_REQ;
            end
          end
          WR_REQ: begin
            if (!wb_stall_i) begin
              wb_stb_o <= 1'b0;
              wb_we_o  <= 1'b0;
              wb_sel_o <= 4'h0;
              state    <= WR_WAIT;
            end
          end
          WR_WAIT: begin
            if (wb_ack_i) begin
              src_w     <= src_w + 30'd1;
              dst_w     <= dst_w + 30'd1;
              remaining <= remaining - LEN_WIDTH'(1);
              wb_cyc_o  <= 1'b0;
              if (remaining == LEN_WIDTH'(1)) begin
                done  <= 1'b1;
                state <= FIN;
              end else begin
                state <= GAP;
              end
            end
          end
          GAP: begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_sel_o <= 4'hF;
`ifdef AVA_DMA_FILL_EN
            if (fill_mode) begin
              wb_we_o  <= 1'b1;
              wb_adr_o <= {dst_w, 2'b00};
              wb_dat_o <= fill_word;
              state    <= WR_REQ;
            end else
`endif
            begin
              wb_we_o  <= 1'b0;
              wb_adr_o <= {src_w, 2'b00};
              state    <= RD_REQ;
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ava_dma.sv
// tb_ava_dma: directed + randomized checks of ava_dma against a behavioural
// memory/transfer model. A reactive Wishbone slave supplies stalls, delayed
// acks and injected errors; a monitor gathers bus statistics.
module tb_ava_dma;
  localparam int LW = 17;
`ifdef AVA_DMA_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, fill_en;
  logic [31:0] src_addr, dst_addr, fill_data;
  logic [LW-1:0] length;
  logic busy, done, err, cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0] sel;
  logic [31:0] dat_i = '0;
  logic ack = 1'b0, stall = 1'b0, berr = 1'b0;

  always #5 clk = ~clk;

  ava_dma #(.LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .fill_en(fill_en), .fill_data(fill_data),
    .busy(busy), .done(done), .err(err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat_o),
    .wb_sel_o(sel), .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_stall_i(stall), .wb_err_i(berr)
  );

  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin passed++; end
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Source memory: a few preloaded words, a deterministic pattern elsewhere.
  logic [31:0] rom [int unsigned];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (rom.exists(a)) return rom[a];
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  // Slave model
  int stall_lo = 0, stall_hi = 0, ack_lo = 0, ack_hi = 0, err_at = 0, rd_cnt = 0;
  int scnt = 0, pcnt = 0;
  logic pend = 1'b0, p_err = 1'b0;
  logic [31:0] p_dat = '0;

  always @(posedge clk) begin
    int s, d;
    logic e;
    logic [31:0] dv;
    ack  <= 1'b0;
    berr <= 1'b0;
    if (rst) begin
      pend  <= 1'b0;
      stall <= 1'b0;
      scnt  <= 0;
    end else begin
      if (cyc && stb) begin
        if (stall) begin
          if (scnt <= 1) stall <= 1'b0;
          scnt <= scnt - 1;
        end else begin
          d  = int'($urandom_range(ack_hi, ack_lo));
          e  = !we && (rd_cnt + 1 == err_at);
          dv = we ? 32'hBAD0_0000 : mem_rd(adr);
          if (!we) rd_cnt <= rd_cnt + 1;
          if (d == 0) begin
            if (e) berr <= 1'b1;
            else begin ack <= 1'b1; dat_i <= dv; end
          end else begin
            pend <= 1'b1; pcnt <= d; p_err <= e; p_dat <= dv;
          end
        end
      end else begin
        // Arm the stall count for the next request while the strobe is low.
        s = int'($urandom_range(stall_hi, stall_lo));
        stall <= (s > 0);
        scnt  <= s;
      end
      if (pend) begin
        if (pcnt <= 1) begin
          pend <= 1'b0;
          if (p_err) berr <= 1'b1;
          else begin ack <= 1'b1; dat_i <= p_dat; end
        end else pcnt <= pcnt - 1;
      end
    end
  end

  // Monitor, mid-cycle
  int cnum = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0, rd_acc = 0, cyc_hi = 0;
  int gap_cnt = 0, gap_bad = 0, low_run = 0, sviol = 0, outs = 0, oviol = 0, ec = 0, eb = 0;
  logic [63:0] wlog [$];
  logic pss = 1'b0, pwe = 1'b0, perr = 1'b0;
  logic [31:0] padr = '0, pdat = '0;

  always @(negedge clk) begin
    cnum++;
    if (start && !busy) start_cyc = cnum;
    if (done) begin done_cnt++; done_cyc = cnum; end
    if (cyc) cyc_hi++;
    if (!busy) low_run = 0;
    else if (!cyc) low_run++;
    else begin
      if (low_run > 0) begin gap_cnt++; if (low_run != 1) gap_bad++; end
      low_run = 0;
    end
    if (pss && !(cyc && stb && adr == padr && we == pwe && dat_o == pdat)) sviol++;
    if (stb && sel != 4'hF) sviol++;
    pss = cyc && stb && stall; padr = adr; pwe = we; pdat = dat_o;
    if (perr) begin ec++; if (cyc || stb) eb++; end
    perr = berr && cyc;
    if (rst) outs = 0;
    else begin
      if ((ack || berr) && outs > 0) outs--;
      if (cyc && stb && !stall) begin
        outs++;
        if (we) wlog.push_back({adr, dat_o}); else rd_acc++;
      end
      if (outs > 1) oviol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One transfer, checked against the expected word list built from the
  // request parameters: word k goes to dst+4k with src[k] (or the fill word).
  task automatic run(input string tag, input logic [31:0] s, input logic [31:0] d, input int len,
                     input logic fe, input logic [31:0] fd, input int err_k, input int poke,
                     input int exp_lat);
    int w0 = wlog.size(), r0 = rd_acc, dn0 = done_cnt, g0 = gap_cnt, gb0 = gap_bad;
    int sv0 = sviol, ov0 = oviol, ec0 = ec, eb0 = eb, ch0 = cyc_hi;
    int nexp, bad, i;
    logic fa;
    logic [31:0] ea, ed, sb, db;
    err_at = (err_k > 0) ? rd_cnt + err_k : 0;
    src_addr = s; dst_addr = d; length = LW'(len); fill_en = fe; fill_data = fd;
    start = 1'b1;
    step();
    start = 1'b0;
    i = 0;
    while (done_cnt == dn0 && i < 20000) begin
      if (poke > 0 && i == poke) begin
        start = 1'b1; src_addr = 32'h0000_4000; dst_addr = 32'h0000_4400; length = LW'(1);
      end else start = 1'b0;
      step();
      i++;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(done_cnt != dn0), 64'd1);
    step(); step();
    chk({tag, " done_pulses"}, 64'(done_cnt - dn0), 64'd1);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    if (exp_lat > 0) chk({tag, " latency"}, 64'(done_cyc - start_cyc + 1), 64'(exp_lat));
    fa   = fe && FILL;
    nexp = (err_k > 0) ? err_k - 1 : len;
    sb   = {s[31:2], 2'b00};
    db   = {d[31:2], 2'b00};
    chk({tag, " writes"}, 64'(wlog.size() - w0), 64'(nexp));
    bad = 0;
    for (int k = 0; k < nexp && w0 + k < wlog.size(); k++) begin
      ea = db + 32'(4 * k);
      ed = fa ? fd : mem_rd(sb + 32'(4 * k));
      if (wlog[w0 + k] !== {ea, ed}) bad++;
    end
    chk({tag, " bad_words"}, 64'(bad), 64'd0);
    chk({tag, " reads"}, 64'(rd_acc - r0), 64'(fa ? 0 : ((err_k > 0) ? err_k : len)));
    chk({tag, " err"}, 64'(err), 64'(err_k > 0));
    chk({tag, " gaps"}, 64'(gap_cnt - g0), 64'((err_k > 0) ? err_k - 1 : ((len > 0) ? len - 1 : 0)));
    chk({tag, " bus_rules"}, 64'((gap_bad - gb0) + (sviol - sv0) + (oviol - ov0)), 64'd0);
    if (err_k > 0) chk({tag, " cyc_drop"}, {32'(ec - ec0), 32'(eb - eb0)}, {32'd1, 32'd0});
    if (len == 0) chk({tag, " no_cyc"}, 64'(cyc_hi - ch0), 64'd0);
  endtask

  initial begin
    int dn0, i;
    rst = 1'b1; start = 1'b0; fill_en = 1'b0; fill_data = '0;
    src_addr = '0; dst_addr = '0; length = '0;
    for (int k = 0; k < 4; k++) rom[32'h1000 + 32'(4 * k)] = 32'hA0 + 32'(k);
    repeat (3) step();
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst ctl", {61'd0, cyc, stb, we}, 64'd0);
    chk("rst adr_dat", {adr, dat_o}, 64'd0);
    chk("rst sel", 64'(sel), 64'd0);
    rst = 1'b0;
    step();

    run("copy4", 32'h1000, 32'h8000, 4, 1'b0, 32'h0, 0, 0, 21);

    stall_lo = 3; stall_hi = 3; ack_lo = 2; ack_hi = 2;
    run("stall", 32'h1000, 32'h9000, 2, 1'b0, 32'h0, 0, 0, 0);

    stall_lo = 0; stall_hi = 3; ack_lo = 0; ack_hi = 3;
    for (int n = 0; n < 6; n++)
      run("rand", $urandom, $urandom, int'($urandom_range(12, 1)), 1'b0, 32'h0, 0, 0, 0);

    stall_lo = 0; stall_hi = 0; ack_lo = 0; ack_hi = 0;
    run("err", 32'h2000, 32'hA000, 8, 1'b0, 32'h0, 3, 0, 0);
    run("len0", 32'h2000, 32'hA000, 0, 1'b0, 32'h0, 0, 0, 2);
    run("wrap", 32'h3000, 32'hFFFF_FFFC, 2, 1'b0, 32'h0, 0, 0, 11);
    run("busy_start", 32'h1000, 32'hB000, 4, 1'b0, 32'h0, 0, 3, 21);
    run("fill", 32'h5000, 32'h10000, 256, 1'b1, 32'h00FF_00FF, 0, 0, FILL ? 1 + 3 * 256 : 1 + 5 * 256);

    // Reset while a strobe is on the bus.
    src_addr = 32'h1000; dst_addr = 32'hC000; length = LW'(4); fill_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    i = 0;
    while (!stb && i < 50) begin step(); i++; end
    chk("rst_mid stb_reached", 64'(stb), 64'd1);
    dn0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("rst_mid async_drop", {62'd0, cyc, stb}, 64'd0);
    chk("rst_mid busy", 64'(busy), 64'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_mid no_done", 64'(done_cnt - dn0), 64'd0);
    run("after_rst", 32'h1000, 32'hD000, 4, 1'b0, 32'h0, 0, 0, 21);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
